apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Round-robin APB master arbiter: N_REQ requesters share one APB master port.
// Three-state IDLE/SETUP/ACCESS sequencer with a wait-state timeout abort.
module apb_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    write_i,
  input  logic [32*N_REQ-1:0] addr_i,
  input  logic [32*N_REQ-1:0] wdata_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    done_o,
  output logic [31:0]         rdata_o,
  output logic                err_o,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [31:0]         PADDR,
  output logic [31:0]         PWDATA,
  input  logic [31:0]         PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int unsigned IdxW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   win_q, win_d;

  logic [31:0]       addr_arr  [N_REQ];
  logic [31:0]       wdata_arr [N_REQ];
  logic              found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      addr_arr[k]  = addr_i[32*k +: 32];
      wdata_arr[k] = wdata_i[32*k +: 32];
    end
  end

  // Search begins just after the previous winner and wraps around.
  always_comb begin
    found   = 1'b0;
    win_idx = last_q;
    cand    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d        = StSetup;
          psel_d         = 1'b1;
          penable_d      = 1'b0;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          win_d          = win_idx;
          pwrite_d       = write_i[win_idx];
          paddr_d        = addr_arr[win_idx];
          pwdata_d       = wdata_arr[win_idx];
          cnt_d          = '0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (PREADY) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt_q;
          rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          err_d     = PSLVERR;
          last_d    = win_q;
        end else if (cnt_inc == TimeoutCnt) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt_q;
          rdata_d   = 32'h0;
          err_d     = 1'b1;
          cnt_d     = cnt_inc;
          last_d    = win_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      last_q    <= IdxW'(N_REQ - 1);
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed vector table, hand-written corner sequences and
// randomized multi-requester rounds checked against a transaction-level model.
module tb_apb_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned T = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_i, write_i;
  logic [32*N-1:0] addr_i, wdata_i;
  logic [N-1:0]    gnt_o, done_o;
  logic [31:0]     rdata_o;
  logic            err_o;
  logic            PSEL, PENABLE, PWRITE;
  logic [31:0]     PADDR, PWDATA, PRDATA;
  logic            PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;
  int last_w;

  apb_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req_i   (req_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        serr;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setup_req(input vec_t v);
    write_i[v.k]          = v.wr;
    addr_i[32*v.k +: 32]  = v.addr;
    wdata_i[32*v.k +: 32] = v.wdata;
    req_i[v.k]            = 1'b1;
  endtask

  // Called in the cycle before SETUP; returns in the completion cycle.
  task automatic do_xfer(input vec_t v);
    logic [31:0] onehot;
    int   n;
    bit   ended;
    onehot  = 32'(1) << v.k;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    tick();
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_gnt", 32'(gnt_o), onehot);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", 32'(PWRITE), 32'(v.wr));
    chk("setup_pwdata", PWDATA, v.wdata);
    n     = 0;
    ended = 1'b0;
    for (int i = 0; i < 300 && !ended; i++) begin
      tick();
      if (PSEL && PENABLE) begin
        n++;
        chk("access_gnt", 32'(gnt_o), onehot);
        chk("access_paddr", PADDR, v.addr);
        PREADY  = (n > v.waits);
        PRDATA  = PREADY ? v.prdata : $urandom;
        PSLVERR = PREADY ? v.serr : 1'b1;
      end else begin
        ended = 1'b1;
      end
    end
    if (!ended) chk("access_bound", 32'(ended), 32'd1);
    chk("access_cycles", n, v.exp_acc);
    chk("done", 32'(done_o), onehot);
    chk("rdata", rdata_o, v.exp_rdata);
    chk("err", 32'(err_o), 32'(v.exp_err));
    chk("done_psel", 32'(PSEL), 32'd0);
    chk("done_gnt", 32'(gnt_o), 32'd0);
    req_i[v.k] = 1'b0;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
  endtask

  task automatic reset_dut();
    PRESETn = 1'b0;
    tick();
    tick();
    PRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv [N];
    logic [N-1:0] pend;
    int nxt;

    tbl[0] = '{0, 1'b1, 32'h0000_0000, 32'h0000_0309, 32'h0,         1'b0, 0,    32'h0,         1'b0, 1};
    tbl[1] = '{2, 1'b0, 32'h0000_0004, 32'h0,         32'h0712_2023, 1'b0, 2,    32'h0712_2023, 1'b0, 3};
    tbl[2] = '{1, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0,         1'b1, 0,    32'h0,         1'b1, 1};
    tbl[3] = '{3, 1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_5A5A, 1'b1, 1,    32'hA5A5_5A5A, 1'b1, 2};
    tbl[4] = '{0, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 1000, 32'h0,         1'b1, T};
    tbl[5] = '{2, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'h5555_5555, 1'b0, 5,    32'h0,         1'b0, 6};

    PRESETn = 1'b0;
    req_i   = '0;
    write_i = '0;
    addr_i  = '0;
    wdata_i = '0;
    PRDATA  = '0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    #3;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    reset_dut();

    // Round-robin with all requesters held and a zero-wait slave.
    for (int k = 0; k < N; k++) addr_i[32*k +: 32] = 32'h1000 * (k + 1);
    req_i  = '1;
    PREADY = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (t % 3 == 0) begin
        chk("rr_setup", 32'({PSEL, PENABLE}), 32'b10);
        chk("rr_gnt", 32'(gnt_o), 32'(1) << ((t / 3) % N));
        chk("rr_paddr", PADDR, 32'h1000 * (((t / 3) % N) + 1));
      end else if (t % 3 == 1) begin
        chk("rr_access", 32'({PSEL, PENABLE}), 32'b11);
      end else begin
        chk("rr_done", 32'(done_o), 32'(1) << ((t / 3) % N));
      end
    end
    req_i = '0;
    tick();
    tick();

    // Asynchronous reset during requester 1's ACCESS phase.
    reset_dut();
    req_i  = '1;
    PREADY = 1'b1;
    tick();
    chk("rm_gnt0", 32'(gnt_o), 32'b0001);
    tick();
    tick();
    chk("rm_done0", 32'(done_o), 32'b0001);
    PREADY = 1'b0;
    tick();
    chk("rm_gnt1", 32'(gnt_o), 32'b0010);
    tick();
    chk("rm_access1", 32'({PSEL, PENABLE}), 32'b11);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rm_psel", 32'(PSEL), 32'd0);
    chk("rm_penable", 32'(PENABLE), 32'd0);
    chk("rm_gnt", 32'(gnt_o), 32'd0);
    chk("rm_nodone", 32'(done_o), 32'd0);
    tick();
    chk("rm_nodone_hold", 32'(done_o), 32'd0);
    PRESETn = 1'b1;
    tick();
    chk("rm_first_gnt", 32'(gnt_o), 32'b0001);
    chk("rm_first_setup", 32'({PSEL, PENABLE}), 32'b10);
    // Winner drops its request mid-transfer; it must still complete.
    req_i  = '0;
    PREADY = 1'b1;
    tick();
    tick();
    chk("rm_drop_done", 32'(done_o), 32'b0001);
    PREADY = 1'b0;
    tick();
    chk("rm_idle_psel", 32'(PSEL), 32'd0);
    chk("rm_idle_done", 32'(done_o), 32'd0);
    last_w = 0;

    for (int i = 0; i < 6; i++) begin
      setup_req(tbl[i]);
      do_xfer(tbl[i]);
      last_w = tbl[i].k;
      tick();
      chk("tbl_done_clear", 32'(done_o), 32'd0);
      chk("tbl_err_clear", 32'(err_o), 32'd0);
      chk("tbl_rdata_hold", rdata_o, tbl[i].exp_rdata);
    end

    // Random rounds: a request mask is raised at once, each requester drops on its done.
    for (int r = 0; r < 40; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        rv[k].k      = k;
        rv[k].wr     = 1'($urandom % 2);
        rv[k].addr   = $urandom & 32'hFFFF_FFFC;
        rv[k].wdata  = $urandom;
        rv[k].prdata = $urandom;
        rv[k].serr   = ($urandom % 4 == 0);
        rv[k].waits  = int'($urandom_range(0, 3));
        rv[k].exp_rdata = rv[k].wr ? 32'h0 : rv[k].prdata;
        rv[k].exp_err   = rv[k].serr;
        rv[k].exp_acc   = rv[k].waits + 1;
        if (pend[k]) setup_req(rv[k]);
      end
      for (int g = 0; g < N && pend != '0; g++) begin
        nxt = -1;
        for (int off = 1; off <= N; off++) begin
          if (nxt < 0 && pend[(last_w + off) % N]) nxt = (last_w + off) % N;
        end
        do_xfer(rv[nxt]);
        pend[nxt] = 1'b0;
        last_w    = nxt;
      end
      tick();
      chk("rnd_idle_done", 32'(done_o), 32'd0);
      chk("rnd_idle_psel", 32'(PSEL), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
